dpll_loop_ctrl: RTL
===================

# dpll_loop_ctrl

Synthesizable digital-PLL loop controller clocked on the reference clock. It takes one sampled TDC phase error and one DCO frequency count per reference period and produces the signed DCO control word `dctrl`. It runs a mode FSM: frequency acquisition, phase acquisition, lock, and an optional brake/recover sequence. It sits between the TDC/cycle counter and the DCO. It replaces the fixed-gain behavioural loop filter with parametrised widths, gains, a lock detector and mode control.

## Interface
Parameters:
- `ERR_W`, 13: signed TDC error width.
- `CNT_W`, 10: unsigned frequency-count / divider width.
- `CTRL_W`, 16: signed `dctrl` width.
- `KP`, 10: proportional gain, phase modes.
- `KI`, 1: integral gain, phase modes.
- `KI_FREQ`, 400: integral gain, frequency mode.
- `FACQ_SETTLE`, 2: valid samples discarded after leaving IDLE.
- `FREQ_TOL`, 1: allowed |frequency error| for frequency lock.
- `LOCK_THRESH`, 64: |tdc_err| bound for phase lock.
- `LOCK_COUNT`, 32: consecutive in-bound samples needed to declare lock.
- `BRAKE_CODE`, 2000: integrator decrement applied on brake.
- `BRAKE_HOLD`, 100: brake hold time, in valid samples.
- `BRAKE_DIV`, 300: initial `div_delta` on brake.
- `RECOVER_STEP`, 4: `div_delta` decrement per valid sample.

Ports:
- `refclk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  closes the loop.
- `tdc_valid`  in  1  `tdc_err` and `fmeas` valid this cycle.
- `tdc_err`  in  ERR_W  signed phase error.
- `fmeas`  in  CNT_W  DCO cycles counted in the last reference period.
- `divn`  in  CNT_W  target divide ratio; quasi-static.
- `brake`  in  1  level input; a rising edge requests braking.
- `dctrl`  out  CTRL_W  signed DCO control word.
- `div_delta`  out  CNT_W  current offset subtracted from `divn`.
- `state`  out  3  FSM state encoding.
- `locked`  out  1  lock indicator.

## Operation
- **Integrator.** `accum` is a signed register of CTRL_W+4 bits. Every arithmetic result is clamped to the accum range. `dctrl` is clamped to the signed CTRL_W range.
- **Frequency error.** `ferr = divn - div_delta - fmeas`, computed at CNT_W+2 bits signed.
- **IDLE (0).**
  - `dctrl` holds its last value.
  - `enable=1` → FREQ_ACQ, loading the settle counter with FACQ_SETTLE.
- **FREQ_ACQ (1).**
  - The first FACQ_SETTLE valid samples are ignored.
  - Each later valid sample: `accum += KI_FREQ*ferr`, `dctrl = accum`.
  - 4 consecutive valid samples with |ferr| ≤ FREQ_TOL → PHASE_ACQ.
- **PHASE_ACQ (2).**
  - Each valid sample: `accum += KI*tdc_err`, `dctrl = accum + KP*tdc_err`.
  - Lock counter increments when |tdc_err| ≤ LOCK_THRESH, otherwise clears.
  - Counter reaching LOCK_COUNT → LOCKED, `locked=1`.
- **LOCKED (3).**
  - Same filter as PHASE_ACQ.
  - 4 consecutive samples with |tdc_err| > LOCK_THRESH → PHASE_ACQ, `locked=0`.
- **Full-scale escape (PHASE_ACQ/LOCKED).** 4 consecutive samples with `tdc_err` at the ERR_W minimum or maximum → FREQ_ACQ, `locked=0`, lock counter cleared.
- **BRAKING (4).** Entered on a `brake` rising edge in states 1–5.
  - On entry: `accum -= BRAKE_CODE` once, `div_delta = BRAKE_DIV`, `locked=0`, hold counter = BRAKE_HOLD.
  - The integrator is otherwise frozen and `dctrl = accum`.
  - The hold counter decrements per valid sample; at 0 → RECOVERING.
  - A new rising edge in BRAKING or RECOVERING re-enters BRAKING, re-applying all entry actions.
- **RECOVERING (5).**
  - Frequency-mode filter runs.
  - `div_delta` decreases by RECOVER_STEP per valid sample, saturating at 0.
  - Once `div_delta` reaches 0 → FREQ_ACQ.
- **Leaving the loop.** `enable=0` in any state → IDLE next cycle; `accum`/`dctrl` held, `locked=0`, `div_delta=0`.
- **Edge detector.** Brake rising edges are detected by a registered previous value of `brake`.
- **Cycles without `tdc_valid`.** No filter, counter or FSM update, except `enable` and brake transitions.

## Timing
- **Reset.** `reset` overrides everything. Next edge: `dctrl=0`, `accum=0`, `div_delta=0`, `locked=0`, `state=0`, all counters 0, brake edge register 0.
- **Filter latency.** `dctrl` reflects the sample with `tdc_valid` high at edge N one cycle later, registered at edge N.
- **State transitions.** Take effect at the edge of the deciding sample. The new state's filter law applies from the next valid sample.
- **Priority, same cycle:** `reset` > `enable` fall > brake edge > threshold-based transitions.
- **Brake with no valid sample.** A brake edge taken while `tdc_valid=0` still enters BRAKING that cycle.
- **Brake in IDLE.** Ignored; the edge register still updates.
- **Continuous input.** `tdc_valid` may be high every cycle; the datapath sustains one sample per cycle.

## Configuration
- `DPLL_BRAKE_EN` defined: brake detection, BRAKING/RECOVERING states and `div_delta` logic are present, as above.
- `DPLL_BRAKE_EN` undefined:
  - `brake` is ignored.
  - States 4 and 5 are unreachable and not synthesised.
  - `div_delta` is tied to 0.
  - `ferr = divn - fmeas`.

## Test plan
- **Reset.** Assert `reset` for 2 cycles mid-LOCKED → next edge: `dctrl=0`, `state=0`, `locked=0`, `div_delta=0`.
- **Frequency acquisition.** `enable=1`, `divn=32`, `fmeas=31` for 3 valid samples → first 2 ignored, third gives `dctrl=400`. Then `fmeas=32` ×4 → `state=2`.
- **Lock declare and loss.** In PHASE_ACQ, `tdc_err=10` ×32 → `locked=1` on the 32nd sample. Then `tdc_err=100` ×4 → `state=2`, `locked=0`.
- **Full-scale escape.** `tdc_err=4095` ×4 in LOCKED → `state=1`. `dctrl` is clamped within the signed 16-bit range, with no wrap.
- **Brake (DPLL_BRAKE_EN).** Raise `brake` in LOCKED with `accum=5000` → `dctrl=3000`, `div_delta=300`. After 100 valid samples, `state=5`. After 75 more samples, `div_delta=0` and `state=1`.
- **Without DPLL_BRAKE_EN, and enable priority.**
  - Build without the macro; toggle `brake` in LOCKED → no state change.
  - With the macro built in, drop `enable` in the same cycle as a brake edge → `state=0`.

Source files
------------

// File: rtl/dpll_loop_ctrl.sv
// dpll_loop_ctrl: reference-clocked DPLL loop filter with mode FSM and lock detector.
// The brake/recover sequence and div_delta logic are compiled in only when DPLL_BRAKE_EN is defined.
module dpll_loop_ctrl #(
  parameter int ERR_W        = 13,
  parameter int CNT_W        = 10,
  parameter int CTRL_W       = 16,
  parameter int KP           = 10,
  parameter int KI           = 1,
  parameter int KI_FREQ      = 400,
  parameter int FACQ_SETTLE  = 2,
  parameter int FREQ_TOL     = 1,
  parameter int LOCK_THRESH  = 64,
  parameter int LOCK_COUNT   = 32,
  parameter int BRAKE_CODE   = 2000,
  parameter int BRAKE_HOLD   = 100,
  parameter int BRAKE_DIV    = 300,
  parameter int RECOVER_STEP = 4
) (
  input  logic                     refclk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     tdc_valid_i,
  input  logic signed [ERR_W-1:0]  tdc_err_i,
  input  logic        [CNT_W-1:0]  fmeas_i,
  input  logic        [CNT_W-1:0]  divn_i,
  input  logic                     brake_i,
  output logic signed [CTRL_W-1:0] dctrl_o,
  output logic        [CNT_W-1:0]  div_delta_o,
  output logic        [2:0]        state_o,
  output logic                     locked_o
);

  localparam int ACC_W    = CTRL_W + 4;
  localparam int WIDE_W   = 64;
  localparam int SETTLE_W = $clog2(FACQ_SETTLE + 2);
  localparam int LOCK_W   = $clog2(LOCK_COUNT + 2);

  localparam logic signed [WIDE_W-1:0] ONE        = 1;
  localparam logic signed [WIDE_W-1:0] ACC_MAX    = (ONE <<< (ACC_W - 1)) - ONE;
  localparam logic signed [WIDE_W-1:0] ACC_MIN    = -ACC_MAX - ONE;
  localparam logic signed [WIDE_W-1:0] CTRL_MAX   = (ONE <<< (CTRL_W - 1)) - ONE;
  localparam logic signed [WIDE_W-1:0] CTRL_MIN   = -CTRL_MAX - ONE;
  localparam logic signed [WIDE_W-1:0] KP_W       = KP;
  localparam logic signed [WIDE_W-1:0] KI_W       = KI;
  localparam logic signed [WIDE_W-1:0] KI_FREQ_W  = KI_FREQ;
  localparam logic signed [WIDE_W-1:0] FREQ_TOL_W = FREQ_TOL;
  localparam logic signed [WIDE_W-1:0] LOCK_TH_W  = LOCK_THRESH;
  localparam logic signed [ERR_W-1:0]  ERR_MAX    = {1'b0, {(ERR_W-1){1'b1}}};
  localparam logic signed [ERR_W-1:0]  ERR_MIN    = {1'b1, {(ERR_W-1){1'b0}}};

`ifdef DPLL_BRAKE_EN
  localparam int HOLD_W = $clog2(BRAKE_HOLD + 2);
  localparam logic signed [WIDE_W-1:0] BRAKE_CODE_W = BRAKE_CODE;
  localparam logic        [CNT_W-1:0]  STEP_C       = CNT_W'(RECOVER_STEP);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FREQ_ACQ   = 3'd1,
    ST_PHASE_ACQ  = 3'd2,
    ST_LOCKED     = 3'd3,
    ST_BRAKING    = 3'd4,
    ST_RECOVERING = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FREQ_ACQ  = 3'd1,
    ST_PHASE_ACQ = 3'd2,
    ST_LOCKED    = 3'd3
  } state_t;
`endif

  function automatic logic signed [ACC_W-1:0] clampAcc(input logic signed [WIDE_W-1:0] v);
    if (v > ACC_MAX)      clampAcc = ACC_MAX[ACC_W-1:0];
    else if (v < ACC_MIN) clampAcc = ACC_MIN[ACC_W-1:0];
    else                  clampAcc = v[ACC_W-1:0];
  endfunction

  function automatic logic signed [CTRL_W-1:0] clampCtrl(input logic signed [WIDE_W-1:0] v);
    if (v > CTRL_MAX)      clampCtrl = CTRL_MAX[CTRL_W-1:0];
    else if (v < CTRL_MIN) clampCtrl = CTRL_MIN[CTRL_W-1:0];
    else                   clampCtrl = v[CTRL_W-1:0];
  endfunction

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  accum_q, accum_d;
  logic signed [CTRL_W-1:0] dctrl_q, dctrl_d;
  logic                     locked_q, locked_d;
  logic [SETTLE_W-1:0]      settleCnt_q, settleCnt_d;
  logic [LOCK_W-1:0]        lockCnt_q, lockCnt_d;
  logic [2:0]               freqCnt_q, freqCnt_d;
  logic [2:0]               lossCnt_q, lossCnt_d;
  logic [2:0]               fsCnt_q, fsCnt_d;

  logic signed [CNT_W+1:0]  ferr;
  logic signed [WIDE_W-1:0] accW, errW, ferrW, accFreqW, accPhaseW;
  logic signed [ACC_W-1:0]  accFreq, accPhase;
  logic signed [CTRL_W-1:0] ctrlFreq, ctrlPhase;
  logic                     errInBound, errFullScale, ferrInTol;

`ifdef DPLL_BRAKE_EN
  logic [CNT_W-1:0]         divDelta_q, divDelta_d;
  logic [HOLD_W-1:0]        holdCnt_q, holdCnt_d;
  logic                     brakePrev_q, brakeEdge;
  logic signed [ACC_W-1:0]  accBrake;
  logic signed [WIDE_W-1:0] accBrakeW;
  logic signed [CTRL_W-1:0] ctrlBrake;

  assign brakeEdge   = brake_i & ~brakePrev_q;
  assign ferr        = $signed({2'b00, divn_i}) - $signed({2'b00, divDelta_q})
                     - $signed({2'b00, fmeas_i});
  assign accBrake    = clampAcc(accW - BRAKE_CODE_W);
  assign accBrakeW   = accBrake;
  assign ctrlBrake   = clampCtrl(accBrakeW);
  assign div_delta_o = divDelta_q;
`else
  logic unusedBrake;
  assign unusedBrake = brake_i;
  assign ferr        = $signed({2'b00, divn_i}) - $signed({2'b00, fmeas_i});
  assign div_delta_o = '0;
`endif

  // Both filter laws are evaluated every cycle; the FSM picks which one commits.
  assign accW      = accum_q;
  assign errW      = tdc_err_i;
  assign ferrW     = ferr;
  assign accFreq   = clampAcc(accW + KI_FREQ_W * ferrW);
  assign accFreqW  = accFreq;
  assign ctrlFreq  = clampCtrl(accFreqW);
  assign accPhase  = clampAcc(accW + KI_W * errW);
  assign accPhaseW = accPhase;
  assign ctrlPhase = clampCtrl(accPhaseW + KP_W * errW);

  assign errInBound   = (errW <= LOCK_TH_W) && (errW >= -LOCK_TH_W);
  assign errFullScale = (tdc_err_i == ERR_MAX) || (tdc_err_i == ERR_MIN);
  assign ferrInTol    = (ferrW <= FREQ_TOL_W) && (ferrW >= -FREQ_TOL_W);

  always_ff @(posedge refclk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      accum_q     <= '0;
      dctrl_q     <= '0;
      locked_q    <= 1'b0;
      settleCnt_q <= '0;
      lockCnt_q   <= '0;
      freqCnt_q   <= '0;
      lossCnt_q   <= '0;
      fsCnt_q     <= '0;
`ifdef DPLL_BRAKE_EN
      divDelta_q  <= '0;
      holdCnt_q   <= '0;
      brakePrev_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      accum_q     <= accum_d;
      dctrl_q     <= dctrl_d;
      locked_q    <= locked_d;
      settleCnt_q <= settleCnt_d;
      lockCnt_q   <= lockCnt_d;
      freqCnt_q   <= freqCnt_d;
      lossCnt_q   <= lossCnt_d;
      fsCnt_q     <= fsCnt_d;
`ifdef DPLL_BRAKE_EN
      divDelta_q  <= divDelta_d;
      holdCnt_q   <= holdCnt_d;
      brakePrev_q <= brake_i;
`endif
    end
  end

  // Priority: enable fall, then leaving IDLE, then brake edge, then per-sample mode logic.
  always_comb begin
    state_d     = state_q;
    accum_d     = accum_q;
    dctrl_d     = dctrl_q;
    locked_d    = locked_q;
    settleCnt_d = settleCnt_q;
    lockCnt_d   = lockCnt_q;
    freqCnt_d   = freqCnt_q;
    lossCnt_d   = lossCnt_q;
    fsCnt_d     = fsCnt_q;
`ifdef DPLL_BRAKE_EN
    divDelta_d  = divDelta_q;
    holdCnt_d   = holdCnt_q;
`endif
    if (!enable_i) begin
      state_d   = ST_IDLE;
      locked_d  = 1'b0;
      lockCnt_d = '0;
      freqCnt_d = '0;
      lossCnt_d = '0;
      fsCnt_d   = '0;
`ifdef DPLL_BRAKE_EN
      divDelta_d = '0;
      holdCnt_d  = '0;
`endif
    end else if (state_q == ST_IDLE) begin
      state_d     = ST_FREQ_ACQ;
      settleCnt_d = SETTLE_W'(FACQ_SETTLE);
    end
`ifdef DPLL_BRAKE_EN
    else if (brakeEdge) begin
      state_d    = ST_BRAKING;
      accum_d    = accBrake;
      dctrl_d    = ctrlBrake;
      divDelta_d = CNT_W'(BRAKE_DIV);
      holdCnt_d  = HOLD_W'(BRAKE_HOLD);
      locked_d   = 1'b0;
      lockCnt_d  = '0;
      freqCnt_d  = '0;
      lossCnt_d  = '0;
      fsCnt_d    = '0;
    end
`endif
    else if (tdc_valid_i) begin
      case (state_q)
        ST_FREQ_ACQ: begin
          if (settleCnt_q != '0) begin
            settleCnt_d = settleCnt_q - 1'b1;
          end else begin
            accum_d = accFreq;
            dctrl_d = ctrlFreq;
            if (!ferrInTol) begin
              freqCnt_d = '0;
            end else if (freqCnt_q == 3'd3) begin
              state_d   = ST_PHASE_ACQ;
              freqCnt_d = '0;
            end else begin
              freqCnt_d = freqCnt_q + 3'd1;
            end
          end
        end
        ST_PHASE_ACQ, ST_LOCKED: begin
          accum_d = accPhase;
          dctrl_d = ctrlPhase;
          if (errFullScale && fsCnt_q == 3'd3) begin
            state_d   = ST_FREQ_ACQ;
            locked_d  = 1'b0;
            lockCnt_d = '0;
            lossCnt_d = '0;
            fsCnt_d   = '0;
          end else begin
            fsCnt_d = errFullScale ? fsCnt_q + 3'd1 : 3'd0;
            if (state_q == ST_PHASE_ACQ) begin
              if (!errInBound) begin
                lockCnt_d = '0;
              end else begin
                lockCnt_d = lockCnt_q + 1'b1;
                if (lockCnt_q == LOCK_W'(LOCK_COUNT - 1)) begin
                  state_d   = ST_LOCKED;
                  locked_d  = 1'b1;
                  lossCnt_d = '0;
                end
              end
            end else if (errInBound) begin
              lossCnt_d = '0;
            end else if (lossCnt_q == 3'd3) begin
              state_d   = ST_PHASE_ACQ;
              locked_d  = 1'b0;
              lockCnt_d = '0;
              lossCnt_d = '0;
            end else begin
              lossCnt_d = lossCnt_q + 3'd1;
            end
          end
        end
`ifdef DPLL_BRAKE_EN
        ST_BRAKING: begin
          if (holdCnt_q <= HOLD_W'(1)) begin
            holdCnt_d = '0;
            state_d   = ST_RECOVERING;
          end else begin
            holdCnt_d = holdCnt_q - HOLD_W'(1);
          end
        end
        ST_RECOVERING: begin
          accum_d = accFreq;
          dctrl_d = ctrlFreq;
          if (divDelta_q <= STEP_C) begin
            divDelta_d = '0;
            state_d    = ST_FREQ_ACQ;
          end else begin
            divDelta_d = divDelta_q - STEP_C;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign dctrl_o  = dctrl_q;
  assign state_o  = state_q;
  assign locked_o = locked_q;

endmodule
